// File: rtl/spi_apb_master.sv
// spi_apb_master: valid/ready command port to APB requester with PREADY timeout and error counting
module spi_apb_master #(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [CNT_W-1:0]  err_count,
    output logic              busy,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);
    localparam int WC_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t            state;
    logic [WC_W-1:0]   wcnt;
    logic              timeout_hit;
    logic              fail;
    // Abort threshold: the TIMEOUT-th ACCESS cycle without ready; TIMEOUT=0 never aborts
    assign timeout_hit = (TIMEOUT != 0) && (int'(wcnt) == TIMEOUT - 1);
    // A completed transfer errs on slave error, or on abort when ready is still low
    assign fail        = PREADY ? PSLVERR : 1'b1;
    // A pending response blocks new commands
    assign cmd_ready   = (state == IDLE) && !rsp_valid;
    // APB sequencing, response capture and error counting
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            wcnt        <= '0;
            busy        <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            err_count   <= '0;
        end else begin
            if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
            case (state)
                IDLE: if (cmd_valid && cmd_ready) begin
                    state  <= SETUP;
                    busy   <= 1'b1;
                    PSEL   <= 1'b1;
                    PWRITE <= cmd_write;
                    PADDR  <= cmd_addr;
                    PWDATA <= cmd_wdata;
                    wcnt   <= '0;
                end
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
                end
                ACCESS: if (PREADY || timeout_hit) begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    PSEL        <= 1'b0;
                    PENABLE     <= 1'b0;
                    rsp_valid   <= 1'b1;
                    rsp_err     <= fail;
                    rsp_timeout <= !PREADY;
                    rsp_rdata   <= (PREADY && !PWRITE) ? PRDATA : '0;
                    if (fail && err_count != '1) err_count <= err_count + 1'b1;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_apb_master.sv
// tb_spi_apb_master: randomized scoreboard bench with an APB slave model and response monitor
module tb_spi_apb_master;
    localparam int AW = 3, DW = 8, TO = 4, CW = 3;
    logic PCLK = 0, PRESETn = 0;
    logic cmd_valid = 0, cmd_write = 0, rsp_ready = 0;
    logic [AW-1:0] cmd_addr = 0;
    logic [DW-1:0] cmd_wdata = 0;
    logic cmd_ready, rsp_valid, rsp_err, rsp_timeout, busy;
    logic [DW-1:0] rsp_rdata, PWDATA;
    logic [CW-1:0] err_count;
    logic PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PRDATA = 0;
    logic PREADY = 0, PSLVERR = 0;

    spi_apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .err_count(err_count), .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] rd;
        logic          err;
        logic          tmo;
        logic [CW-1:0] cnt;
        int            nacc;
    } exp_t;
    typedef struct {
        int            waits;
        logic          err;
        logic [DW-1:0] rd;
    } plan_t;

    exp_t  exp_q[$];
    plan_t plan_q[$];
    int    checks = 0, errors = 0;
    int    model_cnt = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", n, act, req, $time);
        end
    endtask

    // Issue one command and record what the transfer must produce.
    // waits = ACCESS cycles with PREADY low before the slave answers.
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int waits, input logic perr, input logic [DW-1:0] rd);
        exp_t  e;
        plan_t p;
        bit    ok = 0;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) begin ok = 1; break; end
            @(negedge PCLK);
        end
        chk("cmd_accept", 32'(ok), 1);
        if (ok) begin
            e.w = w; e.a = a; e.d = d;
            e.tmo  = (waits >= TO);
            e.err  = e.tmo || perr;
            e.rd   = (e.tmo || w) ? '0 : rd;
            if (e.err && model_cnt < (1 << CW) - 1) model_cnt++;
            e.cnt  = CW'(model_cnt);
            e.nacc = e.tmo ? TO : waits + 1;
            exp_q.push_back(e);
            p.waits = waits; p.err = perr; p.rd = rd;
            plan_q.push_back(p);
        end
        @(negedge PCLK);
        cmd_valid = 0; cmd_write = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = DW'($urandom);
    endtask

    // APB slave model: ready after the planned number of wait cycles; junk data/error otherwise
    int    acc = 0;
    plan_t cur;
    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            if (acc == 0) begin
                if (plan_q.size() > 0) cur = plan_q.pop_front();
                else begin cur.waits = 0; cur.err = 0; cur.rd = 0; end
            end
            PREADY  = (acc == cur.waits);
            PSLVERR = PREADY ? cur.err : 1'($urandom);
            PRDATA  = PREADY ? cur.rd : ~cur.rd;
            acc++;
        end else begin
            acc = 0;
            PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = DW'($urandom);
        end
    end

    // Monitor: protocol checks, response scoreboard, hold-stability under backpressure
    logic          held = 0;
    exp_t          me;
    logic [DW-1:0] s_rd;
    logic          s_err, s_tmo;
    int            nacc = 0;
    always @(negedge PCLK) begin
        if (!PRESETn) begin
            held = 0; nacc = 0; rsp_ready = 0;
        end else begin
            chk("penable_without_psel", 32'(PENABLE && !PSEL), 0);
            if (PSEL) begin
                if (exp_q.size() > 0) begin
                    chk("paddr", 32'(PADDR), 32'(exp_q[0].a));
                    chk("pwrite", 32'(PWRITE), 32'(exp_q[0].w));
                    chk("pwdata", 32'(PWDATA), 32'(exp_q[0].d));
                end else chk("psel_without_cmd", 32'(PSEL), 0);
            end
            if (PSEL && PENABLE) nacc++;
            if (held && rsp_ready) begin
                held = 0;
                chk("rsp_valid_drop", 32'(rsp_valid), 0);
            end else if (held) begin
                chk("hold_valid", 32'(rsp_valid), 1);
                chk("hold_rdata", 32'(rsp_rdata), 32'(s_rd));
                chk("hold_err", 32'(rsp_err), 32'(s_err));
                chk("hold_timeout", 32'(rsp_timeout), 32'(s_tmo));
                chk("hold_cmd_ready", 32'(cmd_ready), 0);
            end else if (rsp_valid) begin
                if (exp_q.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 0);
                else begin
                    me = exp_q.pop_front();
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(me.rd));
                    chk("rsp_err", 32'(rsp_err), 32'(me.err));
                    chk("rsp_timeout", 32'(rsp_timeout), 32'(me.tmo));
                    chk("err_count", 32'(err_count), 32'(me.cnt));
                    chk("access_cycles", 32'(nacc), 32'(me.nacc));
                end
                chk("rsp_cmd_ready", 32'(cmd_ready), 0);
                s_rd = rsp_rdata; s_err = rsp_err; s_tmo = rsp_timeout;
                held = 1; nacc = 0;
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic drain();
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge PCLK);
        chk("drain", 32'(exp_q.size()), 0);
    endtask

    initial begin
        repeat (3) @(negedge PCLK);
        chk("rst_psel", 32'(PSEL), 0);
        chk("rst_penable", 32'(PENABLE), 0);
        chk("rst_pwrite", 32'(PWRITE), 0);
        chk("rst_paddr", 32'(PADDR), 0);
        chk("rst_pwdata", 32'(PWDATA), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_fields", {rsp_rdata, rsp_err, rsp_timeout}, 0);
        chk("rst_err_count", 32'(err_count), 0);
        chk("rst_busy", 32'(busy), 0);
        PRESETn = 1;
        @(negedge PCLK);
        chk("idle_cmd_ready", 32'(cmd_ready), 1);
        issue(1, 0, 8'h5C, 0, 0, 8'hEE);
        issue(0, 5, 8'h00, 1, 0, 8'hA7);
        issue(1, 2, 8'h11, 0, 1, 8'h00);
        issue(1, 2, 8'h22, 2, 1, 8'h00);
        issue(0, 1, 8'h00, TO + 2, 0, 8'h33);
        issue(0, 1, 8'h00, TO - 1, 0, 8'h44);
        repeat (80) begin
            issue(1'($urandom), AW'($urandom), DW'($urandom), $urandom_range(0, TO + 1),
                  $urandom_range(0, 2) == 0, DW'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge PCLK);
        end
        drain();
        issue(0, 3, 8'h00, 20, 0, 8'h55);
        for (int i = 0; i < 20 && !(PSEL && PENABLE); i++) @(negedge PCLK);
        chk("reached_access", 32'(PSEL && PENABLE), 1);
        #2 PRESETn = 0;
        #1;
        chk("arst_psel", 32'(PSEL), 0);
        chk("arst_penable", 32'(PENABLE), 0);
        chk("arst_rsp_valid", 32'(rsp_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        exp_q.delete(); plan_q.delete(); model_cnt = 0;
        repeat (2) @(negedge PCLK);
        PRESETn = 1;
        repeat (5) begin
            @(negedge PCLK);
            chk("post_rst_no_rsp", 32'(rsp_valid), 0);
        end
        chk("post_rst_cmd_ready", 32'(cmd_ready), 1);
        chk("post_rst_err_count", 32'(err_count), 0);
        issue(1, 4, 8'h9A, 0, 1, 8'h00);
        issue(0, 5, 8'h00, 0, 0, 8'h3C);
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_apb_master.md
Name: spi_apb_master

Overview:
APB requester that drives the SPI controller's APB slave register port (CR1/CR2/BR/DR at PADDR 0/1/2/5) from a simple valid/ready command interface.
It sequences the SETUP/ACCESS phases, waits on PREADY with a bounded timeout, and captures PRDATA/PSLVERR.
It returns one response per command.
It sits between the system-side controller (or test sequencer) and the SPI peripheral's APB port.

Parameters:
ADDR_W, 3, width of cmd_addr/PADDR
DATA_W, 8, width of write/read data
TIMEOUT, 16, max ACCESS cycles with PREADY low before abort; 0 disables timeout
CNT_W, 8, width of saturating error counter

Ports:
PCLK  input  1  APB clock, all logic on rising edge
PRESETn  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_W  target register address
cmd_wdata  input  DATA_W  write data
rsp_valid  output  1  response available, held until rsp_ready
rsp_ready  input  1  response consumed
rsp_rdata  output  DATA_W  read data (0 for writes and timeouts)
rsp_err  output  1  PSLVERR seen or timeout
rsp_timeout  output  1  transfer aborted by timeout
err_count  output  CNT_W  saturating count of errored transfers
busy  output  1  FSM not in IDLE
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PWRITE  output  1  APB direction
PADDR  output  ADDR_W  APB address
PWDATA  output  DATA_W  APB write data
PRDATA  input  DATA_W  APB read data
PREADY  input  1  APB ready
PSLVERR  input  1  APB slave error

Behaviour:
- Reset (PRESETn low, async): FSM=IDLE. All outputs 0: PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_*, err_count, busy. wait counter 0.
- Reset mid-transfer: PSEL/PENABLE drop immediately; no response is produced for the aborted command.
- FSM states:
  - IDLE, SETUP, ACCESS; all outputs registered.
  - cmd_ready = (state==IDLE) && !rsp_valid (combinational from registers). A pending response blocks new commands.
  - IDLE -> SETUP on accept: latch cmd_write/addr/wdata into PWRITE/PADDR/PWDATA. Next cycle PSEL=1, PENABLE=0.
  - SETUP -> ACCESS unconditionally after 1 cycle: PSEL=1, PENABLE=1.
  - ACCESS with PREADY=1 sampled: complete. Next cycle: state=IDLE, PSEL=0, PENABLE=0, rsp_valid=1, rsp_err=PSLVERR, rsp_timeout=0. rsp_rdata=PRDATA if read, else 0.
  - ACCESS with PREADY=0: stay; wait counter increments.
  - Timeout: if TIMEOUT!=0 and the wait counter reaches TIMEOUT-1 with PREADY still 0 (i.e. the TIMEOUT-th ACCESS cycle without ready), abort. Next cycle: IDLE, PSEL/PENABLE=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - PREADY=1 on the same cycle as the timeout threshold: normal completion wins.
- Wait counter clears on entering SETUP; width is clog2(TIMEOUT+1).
- PADDR/PWRITE/PWDATA are stable from SETUP through the last ACCESS cycle, and hold their last values in IDLE (no toggling).
- PSLVERR and PRDATA are sampled only on the completing ACCESS cycle; ignored otherwise.
- Response handshake:
  - rsp_valid and the rsp fields hold stable until rsp_valid && rsp_ready; rsp_valid clears the next cycle.
  - cmd_ready rises the cycle after that.
  - rsp_ready while !rsp_valid is ignored.
- err_count: +1 on each response with rsp_err=1 (at rsp_valid assertion); saturates at all-ones and never wraps.
- busy = (state != IDLE).
- Minimum command-to-command spacing: 4 cycles (IDLE accept, SETUP, ACCESS, response) with zero-wait slave and rsp_ready tied high.
- Protocol invariants:
  - PENABLE never 1 while PSEL=0.
  - PENABLE=1 only in the cycle(s) following a SETUP cycle.
  - At most one outstanding command.

Test Plan:
- Write, zero-wait slave: cmd write addr=0 wdata=0x5C, PREADY=1 in ACCESS -> PSEL 1 for 2 cycles, PENABLE 1 for 1 cycle, PADDR=0, PWDATA=0x5C stable throughout; rsp_valid with rsp_err=0, rsp_rdata=0x00.
- Read with 1 wait state (PREADY on 2nd ACCESS cycle), PRDATA=0xA7, addr=5 -> ACCESS lasts 2 cycles; rsp_rdata=0xA7, rsp_err=0; PRDATA values on the non-ready cycle are ignored.
- PSLVERR=1 on the completing cycle of write addr=2 -> rsp_err=1, rsp_timeout=0, err_count 0->1; a second errored transfer makes it 2.
- Timeout with TIMEOUT=4, PREADY held 0 -> exactly 4 ACCESS cycles, then PSEL=0; rsp_err=1, rsp_timeout=1, rsp_rdata=0. Repeat with PREADY=1 on the 4th ACCESS cycle -> normal completion, rsp_timeout=0.
- Response backpressure: rsp_ready=0 for 5 cycles with cmd_valid held -> cmd_ready stays 0 and rsp fields stay stable; rsp_ready=1 -> rsp_valid drops, next command accepted the cycle after.
- Async reset asserted during ACCESS -> PSEL/PENABLE/rsp_valid=0 immediately; after release cmd_ready=1, err_count=0, no stale response.
